// File: rtl/edge_order_bfs_pkg.sv
// Shared types and constants for the breadth-first edge ordering stage.
package edge_order_bfs_pkg;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] NONE = '1;

  typedef enum logic [3:0] {
    StIdle,
    StPop,
    StScanRd,
    StScanChk,
    StEmit,
    StSeedRd,
    StSeedChk,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/edge_order_bfs_node_fifo.sv
// Node queue for the BFS frontier; single-clock FIFO with asynchronous pointer reset.
module node_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign do_push = push && (count_q != (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/edge_order_bfs.sv
// Reorders the raw DFG edge list into BFS order so every emitted edge's 'a' node is already placed.
module edge_order_bfs #(
  parameter int unsigned N_NODE = 16,
  parameter int unsigned N_EDGE = 79,
  parameter int unsigned ROOT   = 0,
  parameter int unsigned W      = edge_order_bfs_pkg::W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         src_rd,
  output logic [W-1:0] src_addr,
  input  logic [W-1:0] src_data,
  input  logic [W-1:0] dst_data,
  output logic         ord_we,
  output logic [W-1:0] ord_addr,
  output logic [W-1:0] ord_a,
  output logic [W-1:0] ord_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] n_comp
);

  import edge_order_bfs_pkg::*;

  localparam int unsigned NW = (N_NODE > 1) ? $clog2(N_NODE) : 1;
  localparam int unsigned EW = (N_EDGE > 1) ? $clog2(N_EDGE) : 1;

  state_e              state_q, ret_q;
  logic [W-1:0]        cur_q, other_q, scan_q, emit_cnt_q;
  logic [N_NODE-1:0]   visited_q;
  logic [N_EDGE-1:0]   used_q;

  logic                fifo_push, fifo_pop, fifo_empty;
  logic [W-1:0]        fifo_din, fifo_dout;
  logic [EW-1:0]       scan_idx;
  logic                src_hit, dst_hit, scan_end;
  logic [W-1:0]        other_nxt;

  assign scan_idx  = scan_q[EW-1:0];
  assign scan_end  = (scan_q == W'(N_EDGE));
  assign src_hit   = (src_data == cur_q);
  assign dst_hit   = (dst_data == cur_q);
  assign other_nxt = src_hit ? dst_data : src_data;

  // Queue pushes happen only in Idle/Emit/SeedChk and pops only in Pop, so they never collide.
  always_comb begin
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    fifo_din  = '0;
    case (state_q)
      StIdle: begin
        if (start) begin
          fifo_push = 1'b1;
          fifo_din  = W'(ROOT);
        end
      end
      StPop: fifo_pop = !fifo_empty;
      StEmit: begin
        if (!visited_q[other_q[NW-1:0]]) begin
          fifo_push = 1'b1;
          fifo_din  = other_q;
        end
      end
      StSeedChk: begin
        if (!used_q[scan_idx]) begin
          fifo_push = 1'b1;
          fifo_din  = src_data;
        end
      end
      default: ;
    endcase
  end

  node_fifo #(
    .DEPTH(N_NODE),
    .W    (W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ret_q      <= StIdle;
      cur_q      <= NONE;
      other_q    <= NONE;
      scan_q     <= '0;
      emit_cnt_q <= '0;
      visited_q  <= '0;
      used_q     <= '0;
      src_rd     <= 1'b0;
      src_addr   <= '0;
      ord_we     <= 1'b0;
      ord_addr   <= '0;
      ord_a      <= '0;
      ord_b      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      n_comp     <= '0;
    end else begin
      src_rd <= 1'b0;
      ord_we <= 1'b0;
      done   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            visited_q  <= N_NODE'(1) << ROOT;
            used_q     <= '0;
            emit_cnt_q <= '0;
            n_comp     <= W'(1);
            busy       <= 1'b1;
            state_q    <= StPop;
          end
        end
        StPop: begin
          scan_q <= '0;
          if (!fifo_empty) begin
            cur_q   <= fifo_dout;
            state_q <= StScanRd;
          end else if (emit_cnt_q < W'(N_EDGE)) begin
            state_q <= StSeedRd;
          end else begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StDone;
          end
        end
        StScanRd: begin
          if (scan_end) begin
            state_q <= StPop;
          end else begin
            src_rd   <= 1'b1;
            src_addr <= scan_q;
            ret_q    <= StScanChk;
            state_q  <= StWait;
          end
        end
        // ROM data lands one cycle after the strobe; this state is the wait slot.
        StWait: state_q <= ret_q;
        StScanChk: begin
          if (!used_q[scan_idx] && (src_hit || dst_hit)) begin
            other_q  <= other_nxt;
            ord_we   <= 1'b1;
            ord_addr <= emit_cnt_q;
            ord_a    <= cur_q;
            ord_b    <= other_nxt;
            state_q  <= StEmit;
          end else begin
            scan_q  <= scan_q + 1'b1;
            state_q <= StScanRd;
          end
        end
        StEmit: begin
          used_q[scan_idx]             <= 1'b1;
          visited_q[other_q[NW-1:0]]   <= 1'b1;
          emit_cnt_q                   <= emit_cnt_q + 1'b1;
          scan_q                       <= scan_q + 1'b1;
          state_q                      <= StScanRd;
        end
        StSeedRd: begin
          if (scan_end) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StDone;
          end else begin
            src_rd   <= 1'b1;
            src_addr <= scan_q;
            ret_q    <= StSeedChk;
            state_q  <= StWait;
          end
        end
        StSeedChk: begin
          if (!used_q[scan_idx]) begin
            visited_q[src_data[NW-1:0]] <= 1'b1;
            n_comp                      <= n_comp + 1'b1;
            state_q                     <= StPop;
          end else begin
            scan_q  <= scan_q + 1'b1;
            state_q <= StSeedRd;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_order_bfs.sv
// Directed bench for edge_order_bfs: small 3/2-edge instances plus a 79-edge two-component list.
module tb_edge_order_bfs;
  import edge_order_bfs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int checks = 0;
  int failures = 0;

  // 3-edge instance
  logic        start_s, src_rd_s, ord_we_s, busy_s, done_s;
  logic [31:0] src_addr_s, src_data_s, dst_data_s, ord_addr_s, ord_a_s, ord_b_s, n_comp_s;
  // 2-edge instance
  logic        start_d, src_rd_d, ord_we_d, busy_d, done_d;
  logic [31:0] src_addr_d, src_data_d, dst_data_d, ord_addr_d, ord_a_d, ord_b_d, n_comp_d;
  // 79-edge instance
  logic        start_l, src_rd_l, ord_we_l, busy_l, done_l;
  logic [31:0] src_addr_l, src_data_l, dst_data_l, ord_addr_l, ord_a_l, ord_b_l, n_comp_l;

  edge_order_bfs #(.N_NODE(16), .N_EDGE(3), .ROOT(0), .W(32)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .src_rd(src_rd_s), .src_addr(src_addr_s),
    .src_data(src_data_s), .dst_data(dst_data_s), .ord_we(ord_we_s), .ord_addr(ord_addr_s),
    .ord_a(ord_a_s), .ord_b(ord_b_s), .busy(busy_s), .done(done_s), .n_comp(n_comp_s)
  );
  edge_order_bfs #(.N_NODE(16), .N_EDGE(2), .ROOT(0), .W(32)) dut_d (
    .clk(clk), .reset(reset), .start(start_d), .src_rd(src_rd_d), .src_addr(src_addr_d),
    .src_data(src_data_d), .dst_data(dst_data_d), .ord_we(ord_we_d), .ord_addr(ord_addr_d),
    .ord_a(ord_a_d), .ord_b(ord_b_d), .busy(busy_d), .done(done_d), .n_comp(n_comp_d)
  );
  edge_order_bfs #(.N_NODE(16), .N_EDGE(79), .ROOT(0), .W(32)) dut_l (
    .clk(clk), .reset(reset), .start(start_l), .src_rd(src_rd_l), .src_addr(src_addr_l),
    .src_data(src_data_l), .dst_data(dst_data_l), .ord_we(ord_we_l), .ord_addr(ord_addr_l),
    .ord_a(ord_a_l), .ord_b(ord_b_l), .busy(busy_l), .done(done_l), .n_comp(n_comp_l)
  );

  // ROM models: address captured on the strobe, data valid the following cycle
  logic [31:0] rs_s [0:3], rd_s [0:3], rs_d [0:1], rd_d [0:1], rs_l [0:127], rd_l [0:127];
  always @(posedge clk) begin
    if (src_rd_s) begin
      src_data_s <= rs_s[src_addr_s[1:0]];
      dst_data_s <= rd_s[src_addr_s[1:0]];
    end
    if (src_rd_d) begin
      src_data_d <= rs_d[src_addr_d[0]];
      dst_data_d <= rd_d[src_addr_d[0]];
    end
    if (src_rd_l) begin
      src_data_l <= rs_l[src_addr_l[6:0]];
      dst_data_l <= rd_l[src_addr_l[6:0]];
    end
  end

  // Write logs and event counters
  logic        clr;
  int          nw_s, nd_s, np_s, np1_s, qmax_s, nw_d, nd_d, nw_l, nd_l;
  logic [31:0] la_s [0:7], lb_s [0:7], lad_s [0:7];
  logic [31:0] la_d [0:7], lb_d [0:7], lad_d [0:7];
  logic [31:0] la_l [0:127], lb_l [0:127], lad_l [0:127];

  always @(negedge clk) begin
    if (clr) begin
      nw_s <= 0; nd_s <= 0; np_s <= 0; np1_s <= 0; qmax_s <= 0;
      nw_d <= 0; nd_d <= 0; nw_l <= 0; nd_l <= 0;
    end else begin
      if (ord_we_s) begin
        la_s[nw_s[2:0]] <= ord_a_s; lb_s[nw_s[2:0]] <= ord_b_s; lad_s[nw_s[2:0]] <= ord_addr_s;
        nw_s <= nw_s + 1;
      end
      if (done_s) nd_s <= nd_s + 1;
      if (dut_s.fifo_push) begin
        np_s <= np_s + 1;
        if (dut_s.fifo_din == 32'd1) np1_s <= np1_s + 1;
      end
      if (int'(dut_s.u_fifo.count_q) > qmax_s) qmax_s <= int'(dut_s.u_fifo.count_q);
      if (ord_we_d) begin
        la_d[nw_d[2:0]] <= ord_a_d; lb_d[nw_d[2:0]] <= ord_b_d; lad_d[nw_d[2:0]] <= ord_addr_d;
        nw_d <= nw_d + 1;
      end
      if (done_d) nd_d <= nd_d + 1;
      if (ord_we_l) begin
        la_l[nw_l[6:0]] <= ord_a_l; lb_l[nw_l[6:0]] <= ord_b_l; lad_l[nw_l[6:0]] <= ord_addr_l;
        nw_l <= nw_l + 1;
      end
      if (done_l) nd_l <= nd_l + 1;
    end
  end

  task automatic clear_logs();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic load_s(input int s0, d0, s1, d1, s2, d2);
    rs_s[0] = s0; rd_s[0] = d0; rs_s[1] = s1; rd_s[1] = d1; rs_s[2] = s2; rd_s[2] = d2;
    rs_s[3] = 0;  rd_s[3] = 0;
  endtask

  task automatic run_s(input int budget, output bit ok);
    ok = 1'b0;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_s) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({busy_s, done_s, ord_we_s, src_rd_s} !== 4'b0) begin
      failures++;
      $display("FAIL reset_strobes: got %b want 0000", {busy_s, done_s, ord_we_s, src_rd_s});
    end
    checks++;
    if (n_comp_s !== 32'd0) begin failures++; $display("FAIL reset_ncomp: got %0d want 0", n_comp_s); end
    checks++;
    if ({ord_addr_s, ord_a_s, ord_b_s, src_addr_s} !== 128'd0) begin
      failures++;
      $display("FAIL reset_buses: got %h want 0", {ord_addr_s, ord_a_s, ord_b_s, src_addr_s});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_chain();
    bit ok;
    logic [31:0] ea [0:2], eb [0:2];
    ea[0] = 0; eb[0] = 1; ea[1] = 1; eb[1] = 2; ea[2] = 2; eb[2] = 3;
    load_s(2, 3, 0, 1, 1, 2);
    clear_logs();
    run_s(2000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL chain_timeout: done not seen, want done"); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (la_s[i[2:0]] !== ea[i] || lb_s[i[2:0]] !== eb[i] || lad_s[i[2:0]] !== i) begin
        failures++;
        $display("FAIL chain_wr%0d: got (%0d,%0d)@%0d want (%0d,%0d)@%0d", i, la_s[i[2:0]],
                 lb_s[i[2:0]], lad_s[i[2:0]], ea[i], eb[i], i);
      end
    end
    checks++;
    if (nw_s != 3 || nd_s != 1) begin
      failures++;
      $display("FAIL chain_counts: got writes=%0d done=%0d want 3/1", nw_s, nd_s);
    end
    checks++;
    if (n_comp_s !== 32'd1 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL chain_ncomp: got n_comp=%0d busy=%b want 1/0", n_comp_s, busy_s);
    end
  endtask

  task automatic test_star();
    bit ok;
    load_s(1, 0, 2, 0, 0, 3);
    clear_logs();
    run_s(2000, ok);
    checks++;
    if (!ok || nw_s != 3) begin
      failures++;
      $display("FAIL star_run: got done=%b writes=%0d want 1/3", ok, nw_s);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (la_s[i[2:0]] !== 32'd0 || lb_s[i[2:0]] !== 32'(i + 1) || lad_s[i[2:0]] !== i) begin
        failures++;
        $display("FAIL star_wr%0d: got (%0d,%0d)@%0d want (0,%0d)@%0d", i, la_s[i[2:0]],
                 lb_s[i[2:0]], lad_s[i[2:0]], i + 1, i);
      end
    end
  endtask

  task automatic test_disconnected();
    bit ok = 1'b0;
    rs_d[0] = 0; rd_d[0] = 1; rs_d[1] = 2; rd_d[1] = 3;
    clear_logs();
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done_d) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || nw_d != 2 || nd_d != 1) begin
      failures++;
      $display("FAIL disc_run: got done=%b writes=%0d pulses=%0d want 1/2/1", ok, nw_d, nd_d);
    end
    checks++;
    if (la_d[0] !== 0 || lb_d[0] !== 1 || lad_d[0] !== 0) begin
      failures++;
      $display("FAIL disc_wr0: got (%0d,%0d)@%0d want (0,1)@0", la_d[0], lb_d[0], lad_d[0]);
    end
    checks++;
    if (la_d[1] !== 2 || lb_d[1] !== 3 || lad_d[1] !== 1) begin
      failures++;
      $display("FAIL disc_wr1: got (%0d,%0d)@%0d want (2,3)@1", la_d[1], lb_d[1], lad_d[1]);
    end
    checks++;
    if (n_comp_d !== 32'd2) begin failures++; $display("FAIL disc_ncomp: got %0d want 2", n_comp_d); end
  endtask

  task automatic test_selfloop_dup();
    bit ok;
    logic [31:0] eb [0:2];
    eb[0] = 0; eb[1] = 1; eb[2] = 1;
    load_s(0, 0, 0, 1, 0, 1);
    clear_logs();
    run_s(2000, ok);
    checks++;
    if (!ok || nw_s != 3) begin
      failures++;
      $display("FAIL loop_run: got done=%b writes=%0d want 1/3", ok, nw_s);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (la_s[i[2:0]] !== 32'd0 || lb_s[i[2:0]] !== eb[i] || lad_s[i[2:0]] !== i) begin
        failures++;
        $display("FAIL loop_wr%0d: got (%0d,%0d)@%0d want (0,%0d)@%0d", i, la_s[i[2:0]],
                 lb_s[i[2:0]], lad_s[i[2:0]], eb[i], i);
      end
    end
    checks++;
    if (np1_s != 1 || np_s != 2 || qmax_s != 1) begin
      failures++;
      $display("FAIL loop_queue: got push1=%0d pushes=%0d qmax=%0d want 1/2/1", np1_s, np_s, qmax_s);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, hit = 1'b0;
    load_s(2, 3, 0, 1, 1, 2);
    clear_logs();
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int i = 0; i < 500; i++) begin
      #1;
      if (nw_s == 1 && dut_s.state_q == StScanChk) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL rstmid_reach: ScanChk after 1 write not seen"); end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy_s, done_s, ord_we_s, src_rd_s} !== 4'b0 || n_comp_s !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_ctrl: got strobes=%b n_comp=%0d want 0/0",
               {busy_s, done_s, ord_we_s, src_rd_s}, n_comp_s);
    end
    checks++;
    if ({ord_addr_s, ord_a_s, ord_b_s, src_addr_s} !== 128'd0) begin
      failures++;
      $display("FAIL rstmid_buses: got %h want 0", {ord_addr_s, ord_a_s, ord_b_s, src_addr_s});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_logs();
    run_s(2000, ok);
    checks++;
    if (!ok || nw_s != 3 || n_comp_s !== 32'd1) begin
      failures++;
      $display("FAIL rstmid_rerun: got done=%b writes=%0d n_comp=%0d want 1/3/1", ok, nw_s, n_comp_s);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (la_s[i[2:0]] !== 32'(i) || lb_s[i[2:0]] !== 32'(i + 1) || lad_s[i[2:0]] !== i) begin
        failures++;
        $display("FAIL rstmid_wr%0d: got (%0d,%0d)@%0d want (%0d,%0d)@%0d", i, la_s[i[2:0]],
                 lb_s[i[2:0]], lad_s[i[2:0]], i, i + 1, i);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok = 1'b0;
    bit busy_seen;
    load_s(2, 3, 0, 1, 1, 2);
    clear_logs();
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (4) @(negedge clk);
    busy_seen = busy_s;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (9) @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done_s) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!busy_seen) begin failures++; $display("FAIL b2b_busy: got busy=0 want 1 during run"); end
    checks++;
    if (!ok || nw_s != 3 || nd_s != 1) begin
      failures++;
      $display("FAIL b2b_counts: got done=%b writes=%0d pulses=%0d want 1/3/1", ok, nw_s, nd_s);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (la_s[i[2:0]] !== 32'(i) || lb_s[i[2:0]] !== 32'(i + 1) || lad_s[i[2:0]] !== i) begin
        failures++;
        $display("FAIL b2b_wr%0d: got (%0d,%0d)@%0d want (%0d,%0d)@%0d", i, la_s[i[2:0]],
                 lb_s[i[2:0]], lad_s[i[2:0]], i, i + 1, i);
      end
    end
  endtask

  // Nodes 0..11 joined by a ring plus chords, nodes 12..15 a separate ring: two components.
  task automatic test_full();
    bit ok = 1'b0;
    bit taken [0:127];
    logic [15:0] seen;
    int bad_order, new_comp, unmatched, bad_addr;
    for (int k = 0; k < 128; k++) begin
      if (k < 70) begin
        rs_l[k] = 32'(k % 12);
        rd_l[k] = 32'((k % 12 + 1 + k / 12) % 12);
      end else begin
        rs_l[k] = 32'(12 + k % 4);
        rd_l[k] = 32'(12 + (k + 1) % 4);
      end
    end
    clear_logs();
    start_l = 1'b1;
    @(negedge clk);
    start_l = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      if (done_l) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || nw_l != 79 || nd_l != 1) begin
      failures++;
      $display("FAIL full_run: got done=%b writes=%0d pulses=%0d want 1/79/1", ok, nw_l, nd_l);
    end
    checks++;
    if (n_comp_l !== 32'd2) begin failures++; $display("FAIL full_ncomp: got %0d want 2", n_comp_l); end
    seen = '0; bad_order = 0; new_comp = 0; bad_addr = 0;
    for (int i = 0; i < 79; i++) begin
      if (lad_l[i[6:0]] !== i) bad_addr++;
      if (i == 0 && la_l[0] !== 32'd0) bad_order++;
      if (i > 0 && !seen[la_l[i[6:0]][3:0]]) new_comp++;
      seen[la_l[i[6:0]][3:0]] = 1'b1;
      seen[lb_l[i[6:0]][3:0]] = 1'b1;
    end
    checks++;
    if (bad_order != 0 || new_comp != 1 || bad_addr != 0) begin
      failures++;
      $display("FAIL full_order: got root_bad=%0d new_comp=%0d bad_addr=%0d want 0/1/0",
               bad_order, new_comp, bad_addr);
    end
    for (int i = 0; i < 128; i++) taken[i] = 1'b0;
    unmatched = 0;
    for (int k = 0; k < 79; k++) begin
      bit found = 1'b0;
      for (int i = 0; i < 79; i++) begin
        if (!found && !taken[i] &&
            ((la_l[i[6:0]] == rs_l[k] && lb_l[i[6:0]] == rd_l[k]) ||
             (la_l[i[6:0]] == rd_l[k] && lb_l[i[6:0]] == rs_l[k]))) begin
          taken[i] = 1'b1;
          found    = 1'b1;
        end
      end
      if (!found) unmatched++;
    end
    checks++;
    if (unmatched != 0) begin
      failures++;
      $display("FAIL full_edges: got %0d source edges missing want 0", unmatched);
    end
  endtask

  initial begin
    reset   = 1'b1;
    clr     = 1'b1;
    start_s = 1'b0;
    start_d = 1'b0;
    start_l = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    test_reset();
    test_chain();
    test_star();
    test_disconnected();
    test_selfloop_dup();
    test_reset_mid();
    test_back_to_back();
    test_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_order_bfs.md
Name: edge_order_bfs

Overview:
- Upstream stage of the placement engine: reads the raw, unordered DFG edge list (src/dst ROMs) and writes a breadth-first-ordered edge list into the ea/eb edge RAMs that placement consumes.
- Ordering guarantee: for every output edge i > 0, endpoint a was already an endpoint of some edge j < i, unless edge i starts a new connected component. Placement therefore always finds node a placed.
- Output orientation: a is the node being expanded, b is its neighbour.

Parameters:
N_NODE, 16, max node count; sizes visited vector and node queue
N_EDGE, 79, number of edges in the source list
ROOT, 0, BFS start node
W, 32, data/address width (node ids and edge indices)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins ordering when idle
src_rd  out  1  read strobe to src and dst ROMs (shared address)
src_addr  out  W  edge index to read
src_data  in  W  source endpoint of addressed edge
dst_data  in  W  destination endpoint of addressed edge
ord_we  out  1  write strobe to ordered ea/eb RAMs
ord_addr  out  W  output edge index
ord_a  out  W  expanded node (to ea)
ord_b  out  W  neighbour node (to eb)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when all N_EDGE edges are written
n_comp  out  W  number of BFS seeds used (connected components touched)

Behaviour:
- Reset: all outputs 0; visited and used vectors cleared; queue emptied; state IDLE. Reset mid-operation aborts immediately. Partial RAM contents are not cleaned up.
- ROM timing: data is sampled two clocks after src_rd is asserted (one wait state), same timing as the other memory consumers.
- IDLE: on start, set visited[ROOT], push ROOT, emit_cnt=0, n_comp=1, busy=1, go to POP. start while busy is ignored.
- POP: if queue non-empty, pop to cur, scan_idx=0, go to SCAN_RD. Otherwise go to SEED_RD if emit_cnt<N_EDGE, else DONE.
- SCAN_RD: if scan_idx==N_EDGE, go to POP. Otherwise assert src_rd with src_addr=scan_idx, then go to WAIT and SCAN_CHK.
- SCAN_CHK: if !used[scan_idx] and (src==cur or dst==cur), set other = (src==cur)?dst:src and go to EMIT. Otherwise scan_idx++ and go to SCAN_RD.
- EMIT: single cycle. Drive ord_we=1, ord_addr=emit_cnt, ord_a=cur, ord_b=other. Set used[scan_idx]. If !visited[other], set it and push other. Then emit_cnt++, scan_idx++, go to SCAN_RD.
- SEED_RD/SEED_CHK: scan from index 0 for the first edge with !used. Set visited[src], push src, n_comp++, go to POP. If no unused edge is found, go to DONE; this cannot occur when emit_cnt<N_EDGE.
- DONE: pulse done for 1 cycle, busy=0, return to IDLE.
- Self-loop (src==dst==cur): emitted once, with a=b=cur; no push.
- Edge to an already-visited neighbour: still emitted (a=cur); no push.
- Duplicate edges: each is emitted separately.
- Queue: depth N_NODE. Each node is pushed at most once, so overflow is impossible. Push and pop never occur in the same cycle.
- Node ids >= N_NODE: behaviour undefined. The bench must not drive them.
- Latency: approximately (nodes_popped + n_comp) × N_EDGE × 3 cycles.

Decomposition:
- Shared package:
  - state encodings (IDLE, POP, SCAN_RD, SCAN_CHK, EMIT, SEED_RD, SEED_CHK, WAIT, DONE)
  - NONE = -1 constant
  - width W
- Sub-module node_fifo:
  - synchronous FIFO, depth N_NODE
  - ports push, pop, din, dout, empty
  - asynchronous reset clears the pointers

Test Plan:
- Chain: N_EDGE=3, ROM = (2,3),(0,1),(1,2), ROOT=0 -> writes (0,1)@0, (1,2)@1, (2,3)@2; done pulses once; n_comp=1.
- Star with reversed edges: ROM = (1,0),(2,0),(0,3) -> writes (0,1),(0,2),(0,3) in that order; b is always the leaf.
- Disconnected: ROM = (0,1),(2,3) -> writes (0,1)@0, (2,3)@1; n_comp=2.
- Self-loop plus duplicate: ROM = (0,0),(0,1),(0,1) -> writes (0,0),(0,1),(0,1); node 1 is pushed exactly once (queue count checked).
- Reset asserted mid-SCAN_CHK after 1 write -> all outputs 0 the same cycle; a later start reproduces the full correct order from index 0.
- start re-pulsed while busy -> ignored; output sequence identical to the undisturbed run. Full 79-edge ewf list -> 79 writes with ordering guarantee checked, and the placement engine consuming the result does not print "No solution".
